multiplier_controller_tainttrack: RTL and testbench
===================================================

# multiplier_controller_tainttrack

Control FSM for the taint-tracking add-shift sequential multiplier. It drives the datapath's load, clear and shift strobes and consumes the datapath's `multiplierReg` bits to choose between add and shift-only steps. Every strobe carries a taint bit, and `done` and `busy` carry one too. These taints expose control-flow and timing leakage: a secret multiplier bit changes the operation's latency. The block sits beside the datapath; its strobes connect one-to-one to the datapath's controller inputs.

## Interface
- `WIDTH`, 4: operand width; must match the datapath; must be at least 2.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `start_t`  in  1  taint of `start`.
- `multiplierReg`  in  WIDTH  datapath multiplier register.
- `multiplierReg_t`  in  WIDTH  per-bit taint of `multiplierReg`.
- `rsload`, `rsclear`, `rsshr`, `mrld`, `mdld`  out  1 each  datapath strobes.
- `rsload_t`, `rsclear_t`, `rsshr_t`, `mrld_t`, `mdld_t`  out  1 each  strobe taints.
- `busy`  out  1  operation in progress; high in every state except IDLE.
- `busy_t`  out  1  taint of `busy`.
- `done`  out  1  one-cycle pulse; the product is valid in the datapath.
- `done_t`  out  1  taint of `done`.

## Operation
- State register has 6 states: IDLE, INIT, TEST, ADD, SHIFT, DONE.
- Iteration counter `cnt` is $clog2(WIDTH) bits.
- Sticky control-flow taint register: `ctrl_t`.
- All outputs are Moore outputs, decoded from the state register only. There is no combinational path from any input to any output.
- IDLE
  - Drives all strobes 0.
  - On `start`=1: go to INIT and set `cnt`=0.
  - Every cycle in IDLE: `ctrl_t` <= `start_t`. The decision to start or not start is itself tainted.
- INIT
  - Drives `rsclear`=`mrld`=`mdld`=1 for one cycle.
  - Next state: TEST.
- TEST
  - Drives no strobes.
  - `ctrl_t` <= `ctrl_t` | `multiplierReg_t[cnt]`.
  - `multiplierReg[cnt]`=1: go to ADD. Otherwise go to SHIFT.
- ADD
  - Drives `rsload`=1.
  - Next state: SHIFT.
- SHIFT
  - Drives `rsshr`=1.
  - If `cnt`==WIDTH-1: go to DONE. Otherwise increment `cnt` and go to TEST.
- DONE
  - Drives `done`=1 with no strobes.
  - Next state: IDLE. `ctrl_t` is held on this transition.
- Taint outputs
  - Every `*_t` output equals `ctrl_t` in every state, including IDLE.
  - Rationale: every output is a function of the state, and the state's trajectory is tainted once any branch input was tainted.
- Not taint sources: `multiplierReg_t` bits other than the bit indexed in TEST, and `start_t` outside IDLE.
- `start` while `busy`: ignored, with no effect on state, `cnt` or `ctrl_t`.
- Reset: asynchronous and immediate, including mid-operation.
  - State goes to IDLE; `cnt`=0; `ctrl_t`=0.
  - Every output, including taints, reads 0 while `rst_n`=0.
  - After release, the FSM waits in IDLE for `start`.

## Timing
- Call the rising edge at which `start` is sampled in IDLE edge 0.
  - The state is INIT after edge 0 and TEST after edge 1.
  - Each multiplier bit costs 2 cycles (TEST, SHIFT), or 3 cycles when the bit is 1 (TEST, ADD, SHIFT).
- `done` is high in the cycle after edge 1+2*WIDTH+popcount(multiplier). It lasts exactly one cycle.
- With WIDTH=4:
  - multiplier 0x0: `done` after edge 9.
  - multiplier 0xF: `done` after edge 13.
- `busy` rises after edge 0. It falls at the same edge `done` falls.
- A new `start` is accepted no earlier than the first IDLE cycle after DONE, so there is one idle cycle minimum between operations.
- In the cycle a strobe is high, the datapath acts on it at the next edge. The `cnt` bit tested in TEST is therefore always the value `mrld` loaded in INIT.

## Test plan
- Reset, then `start` pulse with no taint, multiplicand 3, multiplier 5 (WIDTH=4):
  - strobe sequence is INIT, T, A, S, T, S, T, A, S, T, S, DONE;
  - `done` after edge 11; product 15; all `*_t` are 0 throughout.
- Multiplier 0x0, then 0xF, both untainted:
  - `done` after edges 9 and 13 respectively;
  - `rsload` pulses 0 and 4 times respectively.
- `multiplierReg_t`=4'b0100, multiplier 0x6:
  - `*_t` are 0 through the first two TESTs;
  - all `*_t` go to 1 after the third TEST (`cnt`=2) and stay 1 through DONE;
  - `ctrl_t` clears in IDLE when `start_t`=0.
- `start_t`=1 held in IDLE with `start`=0:
  - all `*_t`, including `busy_t`, read 1;
  - no strobe asserts;
  - dropping `start_t` clears them one cycle later.
- `start` re-asserted during TEST and ADD: ignored; cycle count is unchanged from the first scenario.
- `rst_n` low during ADD:
  - `rsload`, `busy` and every `*_t` drop to 0 immediately, without waiting for a clock edge;
  - after release, a fresh `start` completes with the same timing as the first scenario.

Source files
------------

// File: rtl/multiplier_controller_tainttrack.sv
// Control FSM for the taint-tracking add-shift multiplier: sequences the datapath
// strobes from the multiplier bits and carries a sticky control-flow taint on every output.
module multiplier_controller_tainttrack #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             rsload,
    output logic             rsclear,
    output logic             rsshr,
    output logic             mrld,
    output logic             mdld,
    output logic             rsload_t,
    output logic             rsclear_t,
    output logic             rsshr_t,
    output logic             mrld_t,
    output logic             mdld_t,
    output logic             busy,
    output logic             busy_t,
    output logic             done,
    output logic             done_t,
    output logic [2:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ctrl_t_q, ctrl_t_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ctrl_t_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_t_q <= ctrl_t_d;
        end
    end

    // start is a level request with no ready: it is sampled only while IDLE and
    // ignored in every other state; busy tells the requester it will be ignored.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_t_d = ctrl_t_q;
        case (state_q)
            S_IDLE: begin
                ctrl_t_d = start_t;
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            S_INIT: state_d = S_TEST;
            S_TEST: begin
                // Only the bit that steers this branch becomes a taint source.
                ctrl_t_d = ctrl_t_q | multiplierReg_t[cnt_q];
                state_d  = multiplierReg[cnt_q] ? S_ADD : S_SHIFT;
            end
            S_ADD:  state_d = S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_TEST;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rsload  = 1'b0;
        rsclear = 1'b0;
        rsshr   = 1'b0;
        mrld    = 1'b0;
        mdld    = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_INIT: begin
                rsclear = 1'b1;
                mrld    = 1'b1;
                mdld    = 1'b1;
            end
            S_ADD:   rsload = 1'b1;
            S_SHIFT: rsshr  = 1'b1;
            S_DONE:  done   = 1'b1;
            default: ;
        endcase
    end

    // The state trajectory itself is tainted, so every output inherits ctrl_t.
    assign rsload_t  = ctrl_t_q;
    assign rsclear_t = ctrl_t_q;
    assign rsshr_t   = ctrl_t_q;
    assign mrld_t    = ctrl_t_q;
    assign mdld_t    = ctrl_t_q;
    assign busy_t    = ctrl_t_q;
    assign done_t    = ctrl_t_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multiplier_controller_tainttrack.sv
// Bench for multiplier_controller_tainttrack: behavioural datapath, per-cycle expected
// trace built from the bit-serial algorithm, randomized operations plus directed corners.
module tb_multiplier_controller_tainttrack;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         start_t = 1'b0;
    logic [W-1:0] multiplierReg, multiplierReg_t;
    logic rsload, rsclear, rsshr, mrld, mdld;
    logic rsload_t, rsclear_t, rsshr_t, mrld_t, mdld_t;
    logic busy, busy_t, done, done_t;
    logic [2:0] dbg_state;

    logic [W-1:0] op_md = '0, op_mr = '0, op_mrt = '0;
    logic [W-1:0] md_r, mr_r, mrt_r;
    logic [2*W:0] acc;

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    logic [6:0] strobe_vec;
    logic [5:0] taint_vec;
    assign strobe_vec = {busy, done, rsload, rsclear, rsshr, mrld, mdld};
    assign taint_vec  = {busy_t, done_t, rsload_t, rsclear_t, rsshr_t, mrld_t & mdld_t};

    multiplier_controller_tainttrack #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
        .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
        .rsload(rsload), .rsclear(rsclear), .rsshr(rsshr), .mrld(mrld), .mdld(mdld),
        .rsload_t(rsload_t), .rsclear_t(rsclear_t), .rsshr_t(rsshr_t),
        .mrld_t(mrld_t), .mdld_t(mdld_t),
        .busy(busy), .busy_t(busy_t), .done(done), .done_t(done_t),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural datapath driven by the strobes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_r <= '0; mr_r <= '0; mrt_r <= '0; acc <= '0;
        end else begin
            if (mdld) md_r <= op_md;
            if (mrld) begin mr_r <= op_mr; mrt_r <= op_mrt; end
            if (rsclear)     acc <= '0;
            else if (rsload) acc[2*W:W] <= acc[2*W:W] + {1'b0, md_r};
            else if (rsshr)  acc <= acc >> 1;
        end
    end
    assign multiplierReg   = mr_r;
    assign multiplierReg_t = mrt_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected trace entry = {busy,done,rsload,rsclear,rsshr,mrld,mdld, taint}.
    task automatic run_op(input logic [W-1:0] md, input logic [W-1:0] mr,
                          input logic [W-1:0] mrt, input logic st, input bit inject);
        logic t;
        logic [7:0] e;
        int len, done_e, loads;
        exp_q.delete();
        t = st;
        exp_q.push_back({7'b1001011, t});
        for (int i = 0; i < W; i++) begin
            exp_q.push_back({7'b1000000, t});
            t = t | mrt[i];
            if (mr[i]) exp_q.push_back({7'b1010000, t});
            exp_q.push_back({7'b1000100, t});
        end
        exp_q.push_back({7'b1100000, t});
        exp_q.push_back({7'b0000000, t});
        exp_q.push_back({7'b0000000, 1'b0});
        len = exp_q.size();
        done_e = -1;
        loads = 0;
        op_md = md; op_mr = mr; op_mrt = mrt;
        start = 1'b1; start_t = st;
        @(posedge clk);
        #1 start = 1'b0; start_t = 1'b0;
        @(negedge clk);
        for (int j = 0; j < len; j++) begin
            e = exp_q.pop_front();
            check($sformatf("strobes md=%0d mr=%0h e%0d", md, mr, j), 32'(strobe_vec), 32'(e[7:1]));
            check($sformatf("taints mr=%0h mrt=%0h e%0d", mr, mrt, j), 32'(taint_vec), 32'({6{e[0]}}));
            if (done) begin
                if (done_e < 0) done_e = j;
                check($sformatf("product %0d*%0d", md, mr), 32'(acc[2*W-1:0]), 32'(md * mr));
            end
            if (rsload) loads++;
            if (inject && j <= len - 4) begin
                start   = 1'($urandom_range(0, 1));
                start_t = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0; start_t = 1'b0;
            end
            @(negedge clk);
        end
        check($sformatf("done_edge mr=%0h", mr), 32'(done_e), 32'(1 + 2 * W + $countones(mr)));
        check($sformatf("rsload_count mr=%0h", mr), 32'(loads), 32'($countones(mr)));
    endtask

    initial begin
        bit found;
        #1 rst_n = 1'b0;
        #2;
        check("reset strobes", 32'(strobe_vec), 32'd0);
        check("reset taints", 32'(taint_vec), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // directed: 3*5, then 0x0 and 0xF, then a tainted third bit
        run_op(4'd3, 4'd5, 4'd0, 1'b0, 1'b0);
        run_op(4'd7, 4'h0, 4'd0, 1'b0, 1'b0);
        run_op(4'd9, 4'hF, 4'd0, 1'b0, 1'b0);
        run_op(4'd5, 4'h6, 4'b0100, 1'b0, 1'b0);

        // start_t held in IDLE without start
        start_t = 1'b1;
        @(negedge clk);
        check("idle start_t strobes", 32'(strobe_vec), 32'd0);
        check("idle start_t taints", 32'(taint_vec), 32'h3f);
        start_t = 1'b0;
        @(negedge clk);
        check("idle start_t cleared", 32'(taint_vec), 32'd0);

        // start re-asserted while busy
        run_op(4'd3, 4'd5, 4'd0, 1'b0, 1'b1);

        // asynchronous reset in the middle of ADD
        op_md = 4'd3; op_mr = 4'd5; op_mrt = '0;
        start = 1'b1; start_t = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; start_t = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (rsload) found = 1'b1;
        end
        check("reach ADD", 32'(found), 32'd1);
        check("pre-reset taints", 32'(taint_vec), 32'h3f);
        #2 rst_n = 1'b0;
        #1;
        check("async reset strobes", 32'(strobe_vec), 32'd0);
        check("async reset taints", 32'(taint_vec), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_op(4'd3, 4'd5, 4'd0, 1'b0, 1'b0);

        // randomized operations
        for (int r = 0; r < 30; r++) begin
            logic [W-1:0] md, mr, mrt;
            md  = W'($urandom_range(0, 15));
            mr  = W'($urandom_range(0, 15));
            mrt = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : '0;
            run_op(md, mr, mrt, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
